// File: rtl/inst_loader.sv
// inst_loader: boot-time instruction loader sitting in front of the
// single-cycle processor's instruction memory. A big-endian byte stream
// (16-bit count header followed by 3-byte records) is assembled into 19-bit
// words and written sequentially from address 0. The processor is held
// frozen until the whole image has been loaded without error.
// Optional feature: define LOADER_CHECKSUM_EN to require one trailing
// XOR-of-body-bytes checksum byte before the load is declared done.
module inst_loader #(
    parameter int ADDR_W = 8,
    parameter int INST_W = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [INST_W-1:0] imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   load_count
);

    typedef enum logic [3:0] {
        HDR_HI,
        HDR_LO,
        B0,
        B1,
        B2,
        WRITE,
        CHK,
        DONE,
        ERR
    } state_t;

    // Largest legal instruction count: the full memory depth.
    localparam logic [16:0] MAX_N = 17'(1) << ADDR_W;

    state_t            state_q;
    logic              inReady_q;
    logic              imemWe_q;
    logic [ADDR_W-1:0] imemAddr_q;
    logic [INST_W-1:0] imemWdata_q;
    logic              cpuHold_q;
    logic              loadDone_q;
    logic              loadErr_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   instN_q;
    logic [7:0]        hdrHi_q;
    logic [2:0]        b0_q;
    logic [7:0]        b1_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        chk_q;
`endif

    logic              xfer;
    logic [16:0]       hdrN;
    logic              badLen;
    logic [ADDR_W:0]   countNext;

    // Handshake, header decode and the post-write count are shared by
    // several states, so they are computed once here.
    assign xfer      = in_valid && inReady_q;
    assign hdrN      = {1'b0, hdrHi_q, in_data};
    assign badLen    = (hdrN == 17'd0) || (hdrN > MAX_N);
    assign countNext = count_q + {{ADDR_W{1'b0}}, 1'b1};

    // Single loader FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HDR_HI;
            inReady_q   <= 1'b1;
            imemWe_q    <= 1'b0;
            imemAddr_q  <= '0;
            imemWdata_q <= '0;
            cpuHold_q   <= 1'b1;
            loadDone_q  <= 1'b0;
            loadErr_q   <= 1'b0;
            count_q     <= '0;
            instN_q     <= '0;
            hdrHi_q     <= '0;
            b0_q        <= '0;
            b1_q        <= '0;
`ifdef LOADER_CHECKSUM_EN
            chk_q       <= '0;
`endif
        end else begin
            imemWe_q <= 1'b0;
            case (state_q)
                HDR_HI: begin
                    if (xfer) begin
                        hdrHi_q <= in_data;
                        state_q <= HDR_LO;
                    end
                end
                HDR_LO: begin
                    if (xfer) begin
                        if (badLen) begin
                            state_q   <= ERR;
                            inReady_q <= 1'b0;
                            loadErr_q <= 1'b1;
                        end else begin
                            instN_q <= hdrN[ADDR_W:0];
                            state_q <= B0;
                        end
                    end
                end
                B0: begin
                    if (xfer) begin
                        if (in_data[7:3] != 5'd0) begin
                            state_q   <= ERR;
                            inReady_q <= 1'b0;
                            loadErr_q <= 1'b1;
                        end else begin
                            b0_q    <= in_data[2:0];
`ifdef LOADER_CHECKSUM_EN
                            chk_q   <= chk_q ^ in_data;
`endif
                            state_q <= B1;
                        end
                    end
                end
                B1: begin
                    if (xfer) begin
                        b1_q    <= in_data;
`ifdef LOADER_CHECKSUM_EN
                        chk_q   <= chk_q ^ in_data;
`endif
                        state_q <= B2;
                    end
                end
                B2: begin
                    if (xfer) begin
                        imemWe_q    <= 1'b1;
                        imemAddr_q  <= count_q[ADDR_W-1:0];
                        imemWdata_q <= {b0_q, b1_q, in_data};
`ifdef LOADER_CHECKSUM_EN
                        chk_q       <= chk_q ^ in_data;
`endif
                        inReady_q   <= 1'b0;
                        state_q     <= WRITE;
                    end
                end
                WRITE: begin
                    count_q <= countNext;
                    if (countNext == instN_q) begin
`ifdef LOADER_CHECKSUM_EN
                        state_q    <= CHK;
                        inReady_q  <= 1'b1;
`else
                        state_q    <= DONE;
                        loadDone_q <= 1'b1;
                        cpuHold_q  <= 1'b0;
`endif
                    end else begin
                        state_q   <= B0;
                        inReady_q <= 1'b1;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHK: begin
                    if (xfer) begin
                        inReady_q <= 1'b0;
                        if (in_data == chk_q) begin
                            state_q    <= DONE;
                            loadDone_q <= 1'b1;
                            cpuHold_q  <= 1'b0;
                        end else begin
                            state_q   <= ERR;
                            loadErr_q <= 1'b1;
                        end
                    end
                end
`endif
                DONE: begin
                    inReady_q <= 1'b0;
                end
                ERR: begin
                    inReady_q <= 1'b0;
                end
                default: begin
                    state_q   <= ERR;
                    inReady_q <= 1'b0;
                    loadErr_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready   = inReady_q;
    assign imem_we    = imemWe_q;
    assign imem_addr  = imemAddr_q;
    assign imem_wdata = imemWdata_q;
    assign cpu_hold   = cpuHold_q;
    assign load_done  = loadDone_q;
    assign load_err   = loadErr_q;
    assign load_count = count_q;

endmodule
